roce_tx_dma_arbiter: RTL and testbench

Shares one TX packet framer and DMA-metadata path among `N_REQ` independent RoCE DMA requesters, such as per-QP work-queue engines. It grants requesters round-robin and holds each grant for a whole transfer: one metadata beat, then the payload stream up to `tlast`. While the grant is held it passes metadata and payload through to the framer. For RDMA WRITE it also checks the delivered byte count against the declared length, and marks a mismatching frame bad so it is dropped.

---
 rtl/roce_tx_pkg.sv | 49 ++++
 rtl/roce_tx_dma_arbiter_rr_arbiter.sv | 33 +++
 rtl/roce_tx_dma_arbiter.sv | 178 +++++++++++++++++
 tb/tb_roce_tx_dma_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roce_tx_pkg.sv
// Shared types for the RoCE TX DMA arbiter.
//   DMA_META_W   - width of one packed DMA metadata word
//   dma_meta_t   - metadata field layout (transfer_type in bit 0)
//   state_t      - arbiter FSM states
//   keep2count() - bytes carried by a beat (contiguous low-order tkeep ones)
package roce_tx_pkg;

  localparam int DMA_META_W = 266;
  // Widest tkeep keep2count accepts (1024-bit payload); narrower keeps are
  // zero-extended by the caller.
  localparam int KEEP_MAX_W = 128;

  localparam logic TT_SEND  = 1'b0;
  localparam logic TT_WRITE = 1'b1;

  typedef struct packed {
    logic [31:0] dma_length;
    logic [23:0] rem_qpn;
    logic [23:0] loc_qpn;
    logic [23:0] rem_psn;
    logic [31:0] r_key;
    logic [31:0] rem_ip_addr;
    logic [63:0] rem_addr;
    logic        is_immediate;
    logic [31:0] immediate_data;
    logic        transfer_type;
  } dma_meta_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_META,
    ST_DATA
  } state_t;

  // Counts set bits from bit 0 upward and stops at the first clear bit, so a
  // sparse keep such as 0x0B counts 2 and keep = 0 counts 0.
  function automatic logic [31:0] keep2count(input logic [KEEP_MAX_W-1:0] keep);
    logic        run;
    logic [31:0] cnt;
    run = 1'b1;
    cnt = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      if (run && keep[i]) cnt = cnt + 32'd1;
      else                run = 1'b0;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/roce_tx_dma_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
//   req       - request vector
//   last      - index granted last time; the search starts just after it
//   gnt_idx   - first requesting index after last, wrapping
//   gnt_valid - at least one request is present
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    idx       = 0;
    gnt_idx   = last;
    gnt_valid = 1'b0;
    // Walk from the farthest offset to the nearest so the nearest requester
    // after `last` is the final assignment and wins.
    for (int off = N; off >= 1; off--) begin
      idx = (int'(last) + off) % N;
      if (req[idx]) begin
        gnt_idx   = idx[$clog2(N)-1:0];
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/roce_tx_dma_arbiter.sv
// Round-robin arbiter sharing one TX framer between N_REQ DMA requesters.
// A grant is held for one metadata beat plus the payload up to tlast; RDMA
// WRITE payloads are length-checked and a short/long frame is marked bad.
//   s_dma_meta_* / s_axis_* - per-requester metadata and payload inputs
//   m_dma_meta_* / m_axis_* - metadata and payload to the framer
//   status_busy             - not IDLE
//   status_grant            - current or last granted requester
//   status_len_mismatch     - one-cycle pulse after a flagged tlast beat
module roce_tx_dma_arbiter
  import roce_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int N_REQ      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                s_dma_meta_valid,
  output logic [N_REQ-1:0]                s_dma_meta_ready,
  input  logic [N_REQ*DMA_META_W-1:0]     s_dma_meta,
  input  logic [N_REQ*DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [N_REQ*(DATA_WIDTH/8)-1:0] s_axis_tkeep,
  input  logic [N_REQ-1:0]                s_axis_tvalid,
  output logic [N_REQ-1:0]                s_axis_tready,
  input  logic [N_REQ-1:0]                s_axis_tlast,
  input  logic [N_REQ-1:0]                s_axis_tuser,
  output logic                            m_dma_meta_valid,
  input  logic                            m_dma_meta_ready,
  output logic [DMA_META_W-1:0]           m_dma_meta,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]         m_axis_tkeep,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  output logic                            status_busy,
  output logic [$clog2(N_REQ)-1:0]        status_grant,
  output logic                            status_len_mismatch
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int GW     = $clog2(N_REQ);

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [31:0]     byte_cnt_q, byte_cnt_d;
  logic [31:0]     dma_length_q, dma_length_d;
  logic            is_write_q, is_write_d;
  logic            len_mismatch_q, len_mismatch_d;

  logic [GW-1:0]   arb_idx;
  logic            arb_valid;

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .req       (s_dma_meta_valid),
    .last      (last_grant_q),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // Per-requester slices of the packed input buses.
  dma_meta_t             meta_arr [N_REQ];
  logic [DATA_WIDTH-1:0] data_arr [N_REQ];
  logic [KEEP_W-1:0]     keep_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      meta_arr[i] = s_dma_meta[i*DMA_META_W +: DMA_META_W];
      data_arr[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      keep_arr[i] = s_axis_tkeep[i*KEEP_W +: KEEP_W];
    end
  end

  // Granted requester's view and the running length check.
  dma_meta_t             meta_g;
  logic [KEEP_MAX_W-1:0] keep_ext;
  logic [31:0]           beat_sum;
  logic                  in_data, beat_hs, meta_hs, len_bad, flag_beat;

  always_comb begin
    meta_g   = meta_arr[grant_q];
    keep_ext = '0;
    keep_ext[KEEP_W-1:0] = keep_arr[grant_q];
    beat_sum = byte_cnt_q + keep2count(keep_ext);
    in_data  = (state_q == ST_DATA);
    meta_hs  = (state_q == ST_META) && s_dma_meta_valid[grant_q] && m_dma_meta_ready;
    beat_hs  = in_data && s_axis_tvalid[grant_q] && m_axis_tready;
    len_bad  = is_write_q && (beat_sum != dma_length_q);
    // The bad mark is held for as long as the tlast beat is presented.
    flag_beat = in_data && s_axis_tvalid[grant_q] && s_axis_tlast[grant_q] && len_bad;
  end

  // Zero-latency pass-through; only the granted requester ever sees ready.
  always_comb begin
    s_dma_meta_ready = '0;
    s_axis_tready    = '0;
    m_dma_meta       = meta_g;
    m_dma_meta_valid = 1'b0;
    m_axis_tdata     = data_arr[grant_q];
    m_axis_tkeep     = keep_arr[grant_q];
    m_axis_tlast     = s_axis_tlast[grant_q];
    m_axis_tuser     = s_axis_tuser[grant_q] | flag_beat;
    m_axis_tvalid    = 1'b0;
    if (state_q == ST_META) begin
      m_dma_meta_valid          = s_dma_meta_valid[grant_q];
      s_dma_meta_ready[grant_q] = m_dma_meta_ready;
    end
    if (in_data) begin
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    byte_cnt_d     = byte_cnt_q;
    dma_length_d   = dma_length_q;
    is_write_d     = is_write_q;
    len_mismatch_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          state_d = ST_META;
        end
      end
      ST_META: begin
        // A requester that withdraws valid here simply parks the FSM.
        if (meta_hs) begin
          dma_length_d = meta_g.dma_length;
          is_write_d   = (meta_g.transfer_type == TT_WRITE);
          byte_cnt_d   = '0;
          state_d      = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_hs) begin
          byte_cnt_d = beat_sum;
          if (s_axis_tlast[grant_q]) begin
            last_grant_d   = grant_q;
            len_mismatch_d = len_bad;
            state_d        = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      last_grant_q   <= GW'(N_REQ - 1);
      byte_cnt_q     <= '0;
      dma_length_q   <= '0;
      is_write_q     <= 1'b0;
      len_mismatch_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others, independent of order.
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      byte_cnt_q     <= byte_cnt_d;
      dma_length_q   <= dma_length_d;
      is_write_q     <= is_write_d;
      len_mismatch_q <= len_mismatch_d;
    end
  end

  assign status_busy         = (state_q != ST_IDLE);
  assign status_grant        = grant_q;
  assign status_len_mismatch = len_mismatch_q;

endmodule

// File: tb/tb_roce_tx_dma_arbiter.sv
// Self-checking bench for roce_tx_dma_arbiter: a cycle-based driver plays
// planned transfers on each requester and pushes the expected metadata and
// beats; a monitor tracks the transfer protocol, picks the expected winner by
// round-robin rule and pops/compares whenever the DUT hands something over.
module tb_roce_tx_dma_arbiter;

  localparam int DW = 64;
  localparam int N  = 4;
  localparam int KW = DW / 8;
  localparam int MW = 266;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    s_dma_meta_valid, s_dma_meta_ready;
  logic [N*MW-1:0] s_dma_meta;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic [N-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic            m_dma_meta_valid, m_dma_meta_ready;
  logic [MW-1:0]   m_dma_meta;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic            status_busy, status_len_mismatch;
  logic [1:0]      status_grant;

  roce_tx_dma_arbiter #(.DATA_WIDTH(DW), .N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .s_dma_meta_valid(s_dma_meta_valid), .s_dma_meta_ready(s_dma_meta_ready),
    .s_dma_meta(s_dma_meta),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_dma_meta_valid(m_dma_meta_valid), .m_dma_meta_ready(m_dma_meta_ready),
    .m_dma_meta(m_dma_meta),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .status_busy(status_busy), .status_grant(status_grant),
    .status_len_mismatch(status_len_mismatch)
  );

  typedef struct packed {
    logic [7:0]  delay;
    logic        is_write;
    logic [3:0]  nbeats;
    logic [7:0]  last_keep;
    logic        last_bad;
    logic        rand_mode;
    logic [31:0] length;
  } plan_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          bad;
  } beat_t;

  plan_t         plan_q     [N][$];
  logic [MW-1:0] exp_meta_q [N][$];
  beat_t         exp_beat_q [N][$];

  int tests = 0;
  int fails = 0;
  int ready_mode = 0;   // 0 always ready, 1 random, 2 tready toggles
  int mon_state  = 0;   // 0 idle, 1 meta, 2 data

  // Driver-side per-requester progress.
  int            phase    [N];
  int            dly      [N];
  int            beat_idx [N];
  int            nbeat    [N];
  logic          pend     [N];
  logic          rmode    [N];
  logic [KW-1:0] keeps    [N][8];
  logic          bads     [N][8];

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bytes in a beat: position of the lowest clear keep bit.
  function automatic int k2c(input logic [KW-1:0] k);
    logic [KW:0] inv, low;
    int r;
    inv = {1'b1, ~k};
    low = inv & (~inv + 1'b1);
    r = 0;
    for (int b = 0; b <= KW; b++) if (low[b]) r = b;
    return r;
  endfunction

  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic plan_t mk(input int delay, input logic wr, input int nb,
                               input logic [7:0] lk, input logic lb, input logic rm,
                               input logic [31:0] len);
    plan_t p;
    p.delay = 8'(delay); p.is_write = wr; p.nbeats = 4'(nb); p.last_keep = lk;
    p.last_bad = lb; p.rand_mode = rm; p.length = len;
    return p;
  endfunction

  task automatic assert_meta(input int i, input plan_t p);
    logic [287:0] raw;
    logic [31:0]  len;
    int total;
    nbeat[i] = int'(p.nbeats);
    rmode[i] = p.rand_mode;
    total = 0;
    for (int b = 0; b < nbeat[i]; b++) begin
      if (p.rand_mode) begin
        if (b == nbeat[i] - 1) keeps[i][b] = KW'($urandom());
        else case ($urandom() % 6)
          3:       keeps[i][b] = '0;
          4:       keeps[i][b] = KW'($urandom());
          5:       keeps[i][b] = 8'h0F;
          default: keeps[i][b] = '1;
        endcase
        bads[i][b] = ($urandom() % 8 == 0);
      end else begin
        keeps[i][b] = (b == nbeat[i] - 1) ? p.last_keep : '1;
        bads[i][b]  = (b == nbeat[i] - 1) ? p.last_bad : 1'b0;
      end
      total += k2c(keeps[i][b]);
    end
    if (!p.rand_mode)    len = p.length;
    else if (p.is_write) len = ($urandom() % 3 == 2) ? 32'(total + $urandom_range(1, 9)) : 32'(total);
    else                 len = $urandom();
    for (int w = 0; w < 9; w++) raw[w*32 +: 32] = $urandom();
    raw[265:234] = len;
    raw[0]       = p.is_write;
    exp_meta_q[i].push_back(raw[MW-1:0]);
    s_dma_meta[i*MW +: MW] = raw[MW-1:0];
    s_dma_meta_valid[i]    = 1'b1;
    phase[i]               = 1;
  endtask

  task automatic present(input int i);
    beat_t bt;
    if (pend[i] && !(rmode[i] && ($urandom() % 4 == 0))) begin
      bt.data = {$urandom(), $urandom()};
      bt.keep = keeps[i][beat_idx[i]];
      bt.last = (beat_idx[i] == nbeat[i] - 1);
      bt.bad  = bads[i][beat_idx[i]];
      s_axis_tdata[i*DW +: DW] = bt.data;
      s_axis_tkeep[i*KW +: KW] = bt.keep;
      s_axis_tlast[i]  = bt.last;
      s_axis_tuser[i]  = bt.bad;
      s_axis_tvalid[i] = 1'b1;
      exp_beat_q[i].push_back(bt);
      pend[i] = 1'b0;
    end
  endtask

  task automatic drv_step(input int i, input logic mhs, input logic bhs);
    plan_t p;
    case (phase[i])
      0: if (plan_q[i].size() > 0) begin
           p = plan_q[i].pop_front();
           if (p.delay == 0) assert_meta(i, p);
           else begin dly[i] = int'(p.delay); phase[i] = 3; plan_q[i].push_front(p); end
         end
      3: begin
           dly[i]--;
           if (dly[i] == 0) begin p = plan_q[i].pop_front(); assert_meta(i, p); end
         end
      1: if (mhs) begin
           s_dma_meta_valid[i] = 1'b0;
           phase[i] = 2; beat_idx[i] = 0; pend[i] = 1'b1;
           present(i);
         end
      default: begin
        if (bhs) begin
          s_axis_tvalid[i] = 1'b0;
          if (beat_idx[i] == nbeat[i] - 1) phase[i] = 0;
          else begin beat_idx[i]++; pend[i] = 1'b1; end
        end
        if (phase[i] == 2) present(i);
      end
    endcase
  endtask

  // Inputs change 2 time units after the edge; handshakes are sampled on the
  // falling edge, which is what the next rising edge acts on.
  initial begin : driver
    logic [N-1:0] mh, bh;
    logic rs;
    s_dma_meta_valid = '0; s_dma_meta = '0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;
    for (int i = 0; i < N; i++) begin phase[i] = 0; pend[i] = 1'b0; rmode[i] = 1'b0; end
    forever begin
      @(negedge clk);
      mh = s_dma_meta_valid & s_dma_meta_ready;
      bh = s_axis_tvalid & s_axis_tready;
      rs = rst;
      @(posedge clk); #2;
      if (rs) begin
        s_dma_meta_valid = '0; s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;
        for (int i = 0; i < N; i++) begin phase[i] = 0; pend[i] = 1'b0; plan_q[i].delete(); end
      end else begin
        for (int i = 0; i < N; i++) drv_step(i, mh[i], bh[i]);
      end
    end
  end

  initial begin : ready_gen
    m_dma_meta_ready = 1'b0;
    m_axis_tready    = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: begin m_dma_meta_ready = 1'b1; m_axis_tready = 1'b1; end
        1: begin m_dma_meta_ready = ($urandom() % 4 != 0); m_axis_tready = ($urandom() % 4 != 0); end
        default: begin m_dma_meta_ready = 1'b1; m_axis_tready = ~m_axis_tready; end
      endcase
    end
  end

  initial begin : monitor
    int g, lastg, sg, cnt;
    logic [31:0] len, sum;
    logic wr, mm_pend, mis;
    logic [MW-1:0] em;
    beat_t eb;
    g = 0; lastg = N - 1; sg = 0; mm_pend = 1'b0; len = '0; sum = '0; wr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_state = 0; lastg = N - 1; sg = 0; mm_pend = 1'b0;
        for (int i = 0; i < N; i++) begin exp_meta_q[i].delete(); exp_beat_q[i].delete(); end
      end else begin
        check("len_mismatch_pulse", status_len_mismatch, mm_pend);
        mm_pend = 1'b0;
        case (mon_state)
          0: begin
            check("idle_busy", status_busy, 1'b0);
            check("idle_grant", status_grant, sg);
            check("idle_meta_valid", m_dma_meta_valid, 1'b0);
            check("idle_tvalid", m_axis_tvalid, 1'b0);
            check("idle_readies", {s_dma_meta_ready, s_axis_tready}, '0);
            if (|s_dma_meta_valid) begin
              g = rr_pick(lastg, s_dma_meta_valid); sg = g; mon_state = 1;
            end
          end
          1: begin
            check("meta_busy", status_busy, 1'b1);
            check("meta_grant", status_grant, g);
            check("meta_valid", m_dma_meta_valid, s_dma_meta_valid[g]);
            check("meta_ready", s_dma_meta_ready, m_dma_meta_ready ? (N'(1) << g) : '0);
            check("meta_tready", s_axis_tready, '0);
            if (s_dma_meta_valid[g] && m_dma_meta_ready) begin
              if (exp_meta_q[g].size() == 0) check("meta_unexpected", 1'b1, 1'b0);
              else begin
                em = exp_meta_q[g].pop_front();
                check("meta_word", m_dma_meta, em);
                len = em[265:234]; wr = em[0]; sum = '0;
              end
              mon_state = 2;
            end
          end
          default: begin
            check("data_busy", status_busy, 1'b1);
            check("data_grant", status_grant, g);
            check("data_meta_ready", s_dma_meta_ready, '0);
            check("data_tready", s_axis_tready, m_axis_tready ? (N'(1) << g) : '0);
            check("data_tvalid", m_axis_tvalid, s_axis_tvalid[g]);
            if (s_axis_tvalid[g] && m_axis_tready) begin
              if (exp_beat_q[g].size() == 0) begin
                check("beat_unexpected", 1'b1, 1'b0);
                mon_state = 0;
              end else begin
                eb  = exp_beat_q[g].pop_front();
                cnt = k2c(eb.keep);
                mis = eb.last && wr && ((sum + 32'(cnt)) != len);
                check("beat_data", m_axis_tdata, eb.data);
                check("beat_keep", m_axis_tkeep, eb.keep);
                check("beat_last", m_axis_tlast, eb.last);
                check("beat_tuser", m_axis_tuser, eb.bad | mis);
                sum = sum + 32'(cnt);
                if (eb.last) begin mm_pend = mis; lastg = g; mon_state = 0; end
              end
            end
          end
        endcase
      end
    end
  end

  function automatic logic all_done();
    logic d;
    d = (mon_state == 0);
    for (int i = 0; i < N; i++)
      if (plan_q[i].size() != 0 || phase[i] != 0 || exp_meta_q[i].size() != 0 ||
          exp_beat_q[i].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while (!all_done() && c < budget) begin @(posedge clk); c++; end
    tests++;
    if (c >= budget) begin
      fails++;
      $display("FAIL %s: timeout after %0d cycles, required completion", name, c);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // All four at once, one beat each, requester 0 twice: order 0,1,2,3,0.
    for (int i = 0; i < N; i++) plan_q[i].push_back(mk(0, 1'b0, 1, 8'hFF, 1'b0, 1'b0, 32'd8));
    plan_q[0].push_back(mk(0, 1'b0, 1, 8'hFF, 1'b0, 1'b0, 32'd8));
    wait_done("all_four", 400);

    // SEND on requester 2, three full beats.
    plan_q[2].push_back(mk(0, 1'b0, 3, 8'hFF, 1'b0, 1'b0, 32'd24));
    wait_done("send_req2", 400);

    // WRITE of 20 bytes delivered exactly (8+8+4).
    plan_q[1].push_back(mk(0, 1'b1, 3, 8'h0F, 1'b0, 1'b0, 32'd20));
    wait_done("write_ok", 400);

    // WRITE declaring 24 bytes but delivering 20.
    plan_q[3].push_back(mk(0, 1'b1, 3, 8'h0F, 1'b0, 1'b0, 32'd24));
    wait_done("write_short", 400);

    // tready toggling while requester 1 asks for the bus mid-transfer.
    ready_mode = 2;
    plan_q[0].push_back(mk(0, 1'b0, 4, 8'hFF, 1'b0, 1'b0, 32'd32));
    plan_q[1].push_back(mk(3, 1'b1, 1, 8'h3F, 1'b0, 1'b0, 32'd6));
    wait_done("toggle_ready", 400);

    // Randomized mix with random backpressure.
    ready_mode = 1;
    for (int t = 0; t < 48; t++)
      plan_q[$urandom_range(0, N - 1)].push_back(
        mk($urandom_range(0, 3), 1'($urandom() % 2), $urandom_range(1, 8), 8'h00, 1'b0, 1'b1, 32'd0));
    wait_done("random_mix", 8000);

    // Reset in the middle of a payload stream; requester 0 must win next.
    ready_mode = 0;
    plan_q[3].push_back(mk(0, 1'b0, 8, 8'hFF, 1'b0, 1'b0, 32'd64));
    c = 0;
    while (mon_state != 2 && c < 200) begin @(posedge clk); c++; end
    tests++;
    if (c >= 200) begin fails++; $display("FAIL reach_data: timeout, required DATA state"); end
    repeat (2) @(posedge clk);
    do_reset();
    for (int i = 0; i < N; i++) plan_q[i].push_back(mk(0, 1'b0, 1, 8'hFF, 1'b0, 1'b0, 32'd8));
    wait_done("after_reset", 400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
